// File: rtl/proj_qsys_mem_pkg.sv
// Shared types and helpers for the dual-port on-chip RAM: FSM states,
// read-latency selection and byte-lane merge.
package proj_qsys_mem_pkg;

  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_BE = MAX_DW / 8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int unsigned read_latency(input logic outreg);
    return outreg ? 2 : 1;
  endfunction

  // Callers zero-extend narrower words and truncate the result back.
  function automatic logic [MAX_DW-1:0] merge(input logic [MAX_DW-1:0] old_word,
                                              input logic [MAX_DW-1:0] new_word,
                                              input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < MAX_BE; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/proj_qsys_mem_rdpipe.sv
// Per-port readdata/readdatavalid pipeline, depth 1 or 2, stalled by clken
// and flushed by reset.
module proj_qsys_mem_rdpipe
  import proj_qsys_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clken,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  w_v_last;
  logic [DATA_WIDTH-1:0] w_d_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else if (i_clken) begin
      r_v1 <= i_valid;
      if (i_valid) r_d1 <= i_data;
    end
  end

  if (LATENCY >= 2) begin : g_outreg
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_d2;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else if (i_clken) begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign w_v_last = r_v2;
    assign w_d_last = r_d2;
  end else begin : g_direct
    assign w_v_last = r_v1;
    assign w_d_last = r_d1;
  end

  // A frozen valid stays hidden until the next enabled cycle, so each read shows exactly once.
  assign o_valid = w_v_last & i_clken & ~i_reset;
  assign o_data  = w_d_last;

endmodule

// File: rtl/proj_qsys_onchip_memory2_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, cross-port collision
// resolution, same-cycle forwarding and an optional zero-fill after reset.
module proj_qsys_onchip_memory2_dp
  import proj_qsys_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned OUTREG         = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter              INIT_FILE      = "proj_qsys_onchip_memory2_dp.hex"
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clken,
  input  logic [ADDR_WIDTH-1:0]   i_s1_address,
  input  logic                    i_s1_chipselect,
  input  logic                    i_s1_read,
  input  logic                    i_s1_write,
  input  logic [DATA_WIDTH/8-1:0] i_s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   i_s1_writedata,
  output logic [DATA_WIDTH-1:0]   o_s1_readdata,
  output logic                    o_s1_readdatavalid,
  output logic                    o_s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   i_s2_address,
  input  logic                    i_s2_chipselect,
  input  logic                    i_s2_read,
  input  logic                    i_s2_write,
  input  logic [DATA_WIDTH/8-1:0] i_s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   i_s2_writedata,
  output logic [DATA_WIDTH-1:0]   o_s2_readdata,
  output logic                    o_s2_readdatavalid,
  output logic                    o_s2_waitrequest
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned LAT       = read_latency(OUTREG != 0);
  localparam state_t      RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_wait;

  logic                  w_s1_acc, w_s1_we, w_s1_re;
  logic                  w_s2_acc, w_s2_we, w_s2_re;
  logic                  w_same_addr, w_clr_we;
  logic [DATA_WIDTH-1:0] w_s1_wword, w_s2_wword;
  logic [DATA_WIDTH-1:0] w_s1_rword, w_s2_rword;

  // State register; reset takes priority over the clock enable.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_state <= RST_STATE;
    else if (i_clken) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) w_state_next = READY;
      READY:   w_state_next = READY;
      default: w_state_next = READY;
    endcase
  end

  always_comb begin
    w_wait = 1'b1;
    if (!i_reset && i_clken && (r_state == READY)) w_wait = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                           r_cnt <= '0;
    else if (i_clken && r_state == CLEAR)  r_cnt <= r_cnt + ADDR_WIDTH'(1);
  end

  assign o_s1_waitrequest = w_wait;
  assign o_s2_waitrequest = w_wait;

  // A write on a port masks a simultaneous read on that same port.
  assign w_s1_acc    = i_s1_chipselect & (i_s1_read | i_s1_write) & ~w_wait;
  assign w_s2_acc    = i_s2_chipselect & (i_s2_read | i_s2_write) & ~w_wait;
  assign w_same_addr = (i_s1_address == i_s2_address);
  assign w_s1_we     = w_s1_acc & i_s1_write;
  assign w_s1_re     = w_s1_acc & i_s1_read & ~i_s1_write;
  assign w_s2_we     = w_s2_acc & i_s2_write & ~(w_s1_we & w_same_addr);
  assign w_s2_re     = w_s2_acc & i_s2_read & ~i_s2_write;
  assign w_clr_we    = ~i_reset & i_clken & (r_state == CLEAR);

  assign w_s1_wword = DATA_WIDTH'(merge(MAX_DW'(r_mem[i_s1_address]),
                                        MAX_DW'(i_s1_writedata),
                                        MAX_BE'(i_s1_byteenable)));
  assign w_s2_wword = DATA_WIDTH'(merge(MAX_DW'(r_mem[i_s2_address]),
                                        MAX_DW'(i_s2_writedata),
                                        MAX_BE'(i_s2_byteenable)));

  // A read of the word the other port writes this cycle sees the merged new word.
  assign w_s1_rword = (w_s2_we && w_same_addr) ? w_s2_wword : r_mem[i_s1_address];
  assign w_s2_rword = (w_s1_we && w_same_addr) ? w_s1_wword : r_mem[i_s2_address];

  always_ff @(posedge i_clk) begin
    if (w_clr_we) r_mem[r_cnt]        <= '0;
    if (w_s1_we)  r_mem[i_s1_address] <= w_s1_wword;
    if (w_s2_we)  r_mem[i_s2_address] <= w_s2_wword;
  end

  proj_qsys_mem_rdpipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (LAT)
  ) u_rdpipe_s1 (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clken(i_clken),
    .i_valid(w_s1_re),
    .i_data (w_s1_rword),
    .o_valid(o_s1_readdatavalid),
    .o_data (o_s1_readdata)
  );

  proj_qsys_mem_rdpipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (LAT)
  ) u_rdpipe_s2 (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clken(i_clken),
    .i_valid(w_s2_re),
    .i_data (w_s2_rword),
    .o_valid(o_s2_readdatavalid),
    .o_data (o_s2_readdata)
  );

endmodule

// File: tb/tb_proj_qsys_onchip_memory2_dp.sv
// Bench for the dual-port RAM: two instances (read latency 1 and 2) share one
// stimulus stream and are compared every cycle against a word-level model.
module tb_proj_qsys_onchip_memory2_dp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
  logic [3:0]    s1_be, s2_be;
  logic [DW-1:0] s1_wd, s2_wd;

  logic [DW-1:0] rd0_1, rd0_2, rd1_1, rd1_2;
  logic          v0_1, v0_2, v1_1, v1_2;
  logic          w0_1, w0_2, w1_1, w1_2;

  proj_qsys_onchip_memory2_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTREG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_clken(clken),
    .i_s1_address(s1_address), .i_s1_chipselect(s1_cs), .i_s1_read(s1_rd), .i_s1_write(s1_wr),
    .i_s1_byteenable(s1_be), .i_s1_writedata(s1_wd),
    .o_s1_readdata(rd0_1), .o_s1_readdatavalid(v0_1), .o_s1_waitrequest(w0_1),
    .i_s2_address(s2_address), .i_s2_chipselect(s2_cs), .i_s2_read(s2_rd), .i_s2_write(s2_wr),
    .i_s2_byteenable(s2_be), .i_s2_writedata(s2_wd),
    .o_s2_readdata(rd0_2), .o_s2_readdatavalid(v0_2), .o_s2_waitrequest(w0_2)
  );

  proj_qsys_onchip_memory2_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTREG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_clken(clken),
    .i_s1_address(s1_address), .i_s1_chipselect(s1_cs), .i_s1_read(s1_rd), .i_s1_write(s1_wr),
    .i_s1_byteenable(s1_be), .i_s1_writedata(s1_wd),
    .o_s1_readdata(rd1_1), .o_s1_readdatavalid(v1_1), .o_s1_waitrequest(w1_1),
    .i_s2_address(s2_address), .i_s2_chipselect(s2_cs), .i_s2_read(s2_rd), .i_s2_write(s2_wr),
    .i_s2_byteenable(s2_be), .i_s2_writedata(s2_wd),
    .o_s2_readdata(rd1_2), .o_s2_readdatavalid(v1_2), .o_s2_waitrequest(w1_2)
  );

  int checks = 0;
  int failures = 0;

  // Model: word array, remaining clear cycles, enabled-edge count and per-output read queues.
  // Output index k = instance*2 + port (port 0 = s1, 1 = s2); instance i has latency i+1.
  logic [DW-1:0] mmem [DEPTH];
  int            clear_left = DEPTH;
  int            en_cnt = 0;
  logic [DW-1:0] qd   [4][$];
  int            qdue [4][$];
  int            pulses [4] = '{0, 0, 0, 0};
  logic [DW-1:0] last_d [4];
  logic          obs_wait;
  int            snap [4];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mrg(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                        input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic check_outputs();
    logic [DW-1:0] od [4];
    logic          ov [4];
    logic          ow [2];
    logic          exp_v, exp_w;
    od = '{rd0_1, rd0_2, rd1_1, rd1_2};
    ov = '{v0_1, v0_2, v1_1, v1_2};
    ow = '{w0_1, w1_1};
    exp_w = reset || !clken || (clear_left > 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("wait_i%0d", i), {31'b0, ow[i]}, {31'b0, exp_w});
      check($sformatf("wait_s2_match_i%0d", i), {31'b0, (i == 0) ? w0_2 : w1_2}, {31'b0, exp_w});
    end
    for (int k = 0; k < 4; k++) begin
      exp_v = clken && !reset && (qd[k].size() > 0) && (qdue[k][0] == en_cnt);
      check($sformatf("valid_i%0d_s%0d", k / 2, k % 2 + 1), {31'b0, ov[k]}, {31'b0, exp_v});
      if (exp_v) check($sformatf("rdata_i%0d_s%0d", k / 2, k % 2 + 1), od[k], qd[k][0]);
      if (ov[k] === 1'b1) begin
        pulses[k]++;
        last_d[k] = od[k];
      end
    end
    obs_wait = ow[0];
  endtask

  task automatic model_edge();
    logic a1, a2, wr1, wr2, re1, re2;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        qd[k].delete();
        qdue[k].delete();
      end
      clear_left = DEPTH;
      return;
    end
    if (!clken) return;
    for (int k = 0; k < 4; k++) begin
      if (qd[k].size() > 0 && qdue[k][0] == en_cnt) begin
        void'(qd[k].pop_front());
        void'(qdue[k].pop_front());
      end
    end
    en_cnt++;
    if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) foreach (mmem[i]) mmem[i] = '0;
      return;
    end
    a1  = s1_cs && (s1_rd || s1_wr);
    a2  = s2_cs && (s2_rd || s2_wr);
    wr1 = a1 && s1_wr;
    wr2 = a2 && s2_wr && !(wr1 && s1_address == s2_address);
    re1 = a1 && s1_rd && !s1_wr;
    re2 = a2 && s2_rd && !s2_wr;
    if (wr1) mmem[s1_address] = mrg(mmem[s1_address], s1_wd, s1_be);
    if (wr2) mmem[s2_address] = mrg(mmem[s2_address], s2_wd, s2_be);
    // Reads observe the contents as they stand after this edge's writes.
    for (int i = 0; i < 2; i++) begin
      if (re1) begin
        qd[i*2].push_back(mmem[s1_address]);
        qdue[i*2].push_back(en_cnt + i);
      end
      if (re2) begin
        qd[i*2+1].push_back(mmem[s2_address]);
        qdue[i*2+1].push_back(en_cnt + i);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    s1_cs = 0; s1_rd = 0; s1_wr = 0;
    s2_cs = 0; s2_rd = 0; s2_wr = 0;
  endtask

  task automatic set1(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be);
    s1_cs = 1; s1_rd = rd; s1_wr = wr; s1_address = a; s1_wd = d; s1_be = be;
  endtask

  task automatic set2(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] be);
    s2_cs = 1; s2_rd = rd; s2_wr = wr; s2_address = a; s2_wd = d; s2_be = be;
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_wait === 1'b0) break;
      n++;
    end
    check(tag, DW'(n), DW'(DEPTH));
  endtask

  task automatic take_snap();
    for (int k = 0; k < 4; k++) snap[k] = pulses[k];
  endtask

  initial begin
    reset = 1; clken = 1;
    s1_address = '0; s2_address = '0; s1_be = '0; s2_be = '0; s1_wd = '0; s2_wd = '0;
    idle();
    repeat (3) tick();
    reset = 0;
    check("rst_rdata_i0_s1", rd0_1, '0);
    check("rst_rdata_i0_s2", rd0_2, '0);
    check("rst_rdata_i1_s1", rd1_1, '0);
    check("rst_rdata_i1_s2", rd1_2, '0);
    check("rst_valid", {28'b0, v0_1, v0_2, v1_1, v1_2}, '0);
    count_clear("clear_cycles");

    // Read of a cleared word.
    take_snap();
    set1(1, 0, 4'd5, '0, 4'h0); tick(); idle(); repeat (4) tick();
    check("clr_read_i0", last_d[0], 32'h0);
    check("clr_read_i1", last_d[2], 32'h0);
    check("clr_pulses_i0", DW'(pulses[0] - snap[0]), 32'd1);
    check("clr_pulses_i1", DW'(pulses[2] - snap[2]), 32'd1);

    // Byte-enable merge, read from the other port on the next cycle.
    set1(0, 1, 4'd3, 32'h11223344, 4'hF); tick();
    set1(0, 1, 4'd3, 32'hDEADBEEF, 4'b0101); tick(); idle();
    set2(1, 0, 4'd3, '0, 4'h0); tick(); idle(); repeat (4) tick();
    check("be_merge_i0", last_d[1], 32'h11AD33EF);
    check("be_merge_i1", last_d[3], 32'h11AD33EF);

    // Write/write collision: s1 wins.
    set1(0, 1, 4'd7, 32'hAAAAAAAA, 4'hF); set2(0, 1, 4'd7, 32'h55555555, 4'hF); tick(); idle();
    set1(1, 0, 4'd7, '0, 4'h0); tick(); idle(); repeat (4) tick();
    check("ww_collide_i0", last_d[0], 32'hAAAAAAAA);
    check("ww_collide_i1", last_d[2], 32'hAAAAAAAA);

    // Same-cycle cross-port forwarding.
    set1(0, 1, 4'd9, 32'h12345678, 4'hF); set2(1, 0, 4'd9, '0, 4'h0); tick(); idle(); repeat (4) tick();
    check("fwd_i0", last_d[1], 32'h12345678);
    check("fwd_i1", last_d[3], 32'h12345678);

    // Read and write together on one port: no pulse.
    take_snap();
    set1(1, 1, 4'd10, 32'hCAFEF00D, 4'hF); tick(); idle(); repeat (4) tick();
    check("rdwr_nopulse_i0", DW'(pulses[0] - snap[0]), 32'd0);
    check("rdwr_nopulse_i1", DW'(pulses[2] - snap[2]), 32'd0);

    // Streamed s2 reads with a three-cycle clken stall in the middle.
    take_snap();
    for (int i = 0; i < 8; i++) begin
      set2(1, 0, AW'(i), '0, 4'h0);
      if (i == 4) begin
        clken = 0; repeat (3) tick(); clken = 1;
      end
      tick();
    end
    idle(); repeat (5) tick();
    check("stream_pulses_i0", DW'(pulses[1] - snap[1]), 32'd8);
    check("stream_pulses_i1", DW'(pulses[3] - snap[3]), 32'd8);
    check("stream_last_i0", last_d[1], 32'hAAAAAAAA);

    // An accepted read followed by reset is flushed; reset mid-clear restarts the sweep.
    take_snap();
    set1(1, 0, 4'd2, '0, 4'h0); tick(); idle();
    reset = 1; tick(); reset = 0;
    repeat (6) tick();
    reset = 1; tick(); reset = 0;
    count_clear("clear_restart");
    check("flush_i0", DW'(pulses[0] - snap[0]), 32'd0);
    check("flush_i1", DW'(pulses[2] - snap[2]), 32'd0);

    // Randomised traffic on both ports with occasional clock-enable drops.
    for (int n = 0; n < 400; n++) begin
      clken = ($urandom_range(0, 7) != 0);
      s1_cs = $urandom_range(0, 3) != 0; s1_rd = 1'($urandom); s1_wr = 1'($urandom);
      s2_cs = $urandom_range(0, 3) != 0; s2_rd = 1'($urandom); s2_wr = 1'($urandom);
      s1_address = AW'($urandom_range(0, 7)); s2_address = AW'($urandom_range(0, 7));
      s1_be = 4'($urandom); s2_be = 4'($urandom);
      s1_wd = $urandom; s2_wd = $urandom;
      tick();
    end
    clken = 1; idle(); repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
